// File: rtl/lbht_pkg.sv
// Shared constants, clear-FSM state encoding and the history shift helper
// for the local branch history table.
package lbht_pkg;

   localparam int unsigned LBHT_IDX_W      = 10;
   localparam int unsigned LBHT_HIST_W     = 10;
   localparam int unsigned LBHT_RD_PORTS   = 2;
   localparam int unsigned LBHT_CLR_GRP    = 32;
   // Widest history the shift helper can carry; HIST_W must not exceed it.
   localparam int unsigned LBHT_MAX_HIST_W = 64;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } lbht_state_e;

   // Shift a direction bit into the LSB; callers truncate to their HIST_W,
   // which drops the oldest bit.
   function automatic logic [LBHT_MAX_HIST_W-1:0] shl_in(
      input logic [LBHT_MAX_HIST_W-1:0] hist,
      input logic                       dir
   );
      return (hist << 1) | {{(LBHT_MAX_HIST_W-1){1'b0}}, dir};
   endfunction

endpackage

// File: rtl/lbht_entry.sv
// One history table entry: speculative copy, architectural copy and dirty
// flag, with shift, mispredict restore and sweep-clear logic.
module lbht_entry
   import lbht_pkg::*;
#(
   parameter int unsigned HIST_W = LBHT_HIST_W
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              clr_i,
   input  logic              recover_i,
   input  logic              sp_we_i,
   input  logic              sp_dir_i,
   input  logic              cm_we_i,
   input  logic              cm_dir_i,
   output logic [HIST_W-1:0] spec_o
);

   logic [HIST_W-1:0] spec_q, spec_d;
   logic [HIST_W-1:0] arch_q, arch_d;
   logic              dirty_q, dirty_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         spec_q  <= '0;
         arch_q  <= '0;
         dirty_q <= 1'b0;
      end else begin
         spec_q  <= spec_d;
         arch_q  <= arch_d;
         dirty_q <= dirty_d;
      end
   end

   always_comb begin
      spec_d  = spec_q;
      arch_d  = arch_q;
      dirty_d = dirty_q;
      if (clr_i) begin
         spec_d  = '0;
         arch_d  = '0;
         dirty_d = 1'b0;
      end else begin
         if (cm_we_i) begin
            arch_d = HIST_W'(shl_in(LBHT_MAX_HIST_W'(arch_q), cm_dir_i));
         end
         // Restore takes the post-commit arch value so a same-cycle commit is kept.
         if (recover_i) begin
            if (dirty_q) begin
               spec_d = arch_d;
            end
            dirty_d = 1'b0;
         end else if (sp_we_i) begin
            spec_d  = HIST_W'(shl_in(LBHT_MAX_HIST_W'(spec_q), sp_dir_i));
            dirty_d = 1'b1;
         end
      end
   end

   assign spec_o = spec_q;

endmodule

// File: rtl/lbht_spec.sv
// Local branch history table with speculative/architectural copies, one-cycle
// recover and a swept clear. Macro LBHT_RD_BYPASS_EN forwards same-cycle shifts to reads.
module lbht_spec
   import lbht_pkg::*;
#(
   parameter int unsigned IDX_W    = LBHT_IDX_W,
   parameter int unsigned HIST_W   = LBHT_HIST_W,
   parameter int unsigned RD_PORTS = LBHT_RD_PORTS,
   parameter int unsigned CLR_GRP  = LBHT_CLR_GRP
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic [RD_PORTS*IDX_W-1:0]    bht_rd_index_i,
   output logic [RD_PORTS*HIST_W-1:0]   bht_br_hist_o,
   input  logic                         bht_sp_we_i,
   input  logic [IDX_W-1:0]             bht_sp_index_i,
   input  logic                         bht_sp_brdir_i,
   input  logic                         bht_cm_brdir_se_i,
   input  logic [IDX_W-1:0]             bht_cm_index_i,
   input  logic                         bht_cm_brdir_i,
   input  logic                         bht_recover_i,
   input  logic                         bht_clear_req_i,
   output logic                         bht_busy_o
);

   localparam int unsigned DEPTH = 2**IDX_W;
   localparam int unsigned NGRP  = DEPTH / CLR_GRP;
   localparam int unsigned GRP_W = $clog2(CLR_GRP);
   // A single-group sweep still needs a one-bit counter to exist.
   localparam int unsigned CNT_W = (IDX_W > GRP_W) ? (IDX_W - GRP_W) : 1;

   lbht_state_e        state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy;
   logic               sp_ok;
   logic               cm_ok;
   logic               rec_ok;
   logic [HIST_W-1:0]  spec_all [DEPTH];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bht_clear_req_i) begin
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            if (cnt_q == CNT_W'(NGRP - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      busy   = (state_q == CLEAR);
      rec_ok = bht_recover_i & ~busy;
      cm_ok  = bht_cm_brdir_se_i & ~busy;
      sp_ok  = bht_sp_we_i & ~busy & ~bht_recover_i;
   end

   assign bht_busy_o = busy;

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      lbht_entry #(
         .HIST_W (HIST_W)
      ) u_entry (
         .clock     (clock),
         .reset_n   (reset_n),
         .clr_i     (busy && (cnt_q == CNT_W'(i / CLR_GRP))),
         .recover_i (rec_ok),
         .sp_we_i   (sp_ok && (bht_sp_index_i == IDX_W'(i))),
         .sp_dir_i  (bht_sp_brdir_i),
         .cm_we_i   (cm_ok && (bht_cm_index_i == IDX_W'(i))),
         .cm_dir_i  (bht_cm_brdir_i),
         .spec_o    (spec_all[i])
      );
   end

`ifdef LBHT_RD_BYPASS_EN
   logic [HIST_W-1:0] sp_shift;
   assign sp_shift = HIST_W'(shl_in(LBHT_MAX_HIST_W'(spec_all[bht_sp_index_i]), bht_sp_brdir_i));
`endif

   always_comb begin
      bht_br_hist_o = '0;
      for (int unsigned k = 0; k < RD_PORTS; k++) begin
         if (!busy) begin
            bht_br_hist_o[k*HIST_W +: HIST_W] = spec_all[bht_rd_index_i[k*IDX_W +: IDX_W]];
         end
`ifdef LBHT_RD_BYPASS_EN
         if (sp_ok && (bht_rd_index_i[k*IDX_W +: IDX_W] == bht_sp_index_i)) begin
            bht_br_hist_o[k*HIST_W +: HIST_W] = sp_shift;
         end
`endif
      end
   end

endmodule

// File: doc/lbht_spec.md
Name: lbht_spec

Overview:
- Parametrised local branch history table for the fetch stage; successor to the single-copy 1024x10 table.
- Keeps two copies of every entry. A speculative copy is shifted at predict time. An architectural copy is shifted at commit.
- Supports multi-port reads, one-cycle mispredict repair from the architectural copy, and a sequenced table clear (context switch) with a busy handshake.
- Sits between the fetch PC generator (reads, speculative shifts) and the retire unit (commit shifts, recover, clear).

Parameters:
- IDX_W, 10, index width; table depth is 2**IDX_W.
- HIST_W, 10, history bits per entry; feeds the PHT index.
- RD_PORTS, 2, number of independent read ports (fetch width).
- CLR_GRP, 32, entries cleared per cycle during a clear sweep; power of two, at most 2**IDX_W.

Ports:
- clock, in, 1, core clock.
- reset_n, in, 1, asynchronous active-low reset.
- bht_rd_index_i, in, RD_PORTS*IDX_W, read indices from the speculated PC; port k occupies bits [k*IDX_W +: IDX_W].
- bht_br_hist_o, out, RD_PORTS*HIST_W, speculative history per read port.
- bht_sp_we_i, in, 1, speculative shift enable.
- bht_sp_index_i, in, IDX_W, speculative shift index.
- bht_sp_brdir_i, in, 1, predicted direction to shift in.
- bht_cm_brdir_se_i, in, 1, commit shift enable.
- bht_cm_index_i, in, IDX_W, commit index.
- bht_cm_brdir_i, in, 1, confirmed direction.
- bht_recover_i, in, 1, mispredict pulse; restore speculative copy from architectural copy.
- bht_clear_req_i, in, 1, request a full table clear.
- bht_busy_o, out, 1, clear sweep in progress.

Behaviour:
- Reset (asynchronous, active-low):
  - Every spec entry, arch entry and dirty bit is 0.
  - FSM is IDLE, sweep counter is 0, bht_busy_o=0.
  - bht_br_hist_o is 0 (the table is all zero).
- Read: combinational. bht_br_hist_o[k] = spec[rd_index[k]]. Zero latency.
- Speculative shift, on the clock edge when bht_sp_we_i=1:
  - spec[sp_idx] <= {spec[sp_idx][HIST_W-2:0], sp_dir}.
  - dirty[sp_idx] <= 1.
- Commit shift, on the clock edge when bht_cm_brdir_se_i=1:
  - arch[cm_idx] <= {arch[cm_idx][HIST_W-2:0], cm_dir}.
  - The spec copy is not touched by a commit.
- Recover, on the clock edge when bht_recover_i=1:
  - Every entry with dirty=1 gets spec <= arch. The arch value used is the post-commit value when a commit hits the same index in the same cycle.
  - All dirty bits clear.
  - A speculative shift in the same cycle is dropped (wrong path).
  - Completes in one cycle.
- Same-cycle speculative shift and commit to the same index: both apply, each to its own copy.
- Clear FSM:
  - IDLE -> CLEAR on bht_clear_req_i=1.
  - In CLEAR, each cycle zeroes spec, arch and dirty for entries [cnt*CLR_GRP +: CLR_GRP], then cnt increments.
  - CLEAR -> IDLE after the cycle with cnt = 2**IDX_W/CLR_GRP - 1; cnt returns to 0.
  - bht_busy_o is registered: 1 from the cycle after the request through the last sweep cycle; 0 in the cycle after the last sweep cycle.
  - Sweep length is 32 cycles at defaults.
- Priority: clear sweep > recover > speculative shift / commit.
  - While busy: speculative shifts, commits and recovers are ignored, and bht_br_hist_o reads 0.
  - A bht_clear_req_i while busy is ignored (no restart).
  - A request in the same cycle as a recover: the recover takes effect this cycle; the sweep starts next cycle.
- Reset mid-sweep: immediate return to IDLE with the table zeroed.
- Widths: all shifts drop the MSB. Index compares use the full IDX_W. No wrap-around beyond the sweep counter, which has log2(2**IDX_W/CLR_GRP) bits.

Optional Feature:
- LBHT_RD_BYPASS_EN:
  - Defined: if bht_sp_we_i=1, the machine is not busy, recover is 0, and rd_index[k]==sp_idx, then port k returns the shifted value {spec[sp_idx][HIST_W-2:0], sp_dir} in the same cycle.
  - Undefined: reads return the pre-update stored value. The new history is visible the following cycle.

Decomposition:
- Package lbht_pkg: default IDX_W/HIST_W constants, clear FSM state encoding (IDLE=1'b0, CLEAR=1'b1), and the shift-in function shl_in(hist, dir).
- Sub-module lbht_entry: one entry with spec/arch/dirty flops and the per-entry shift, restore and clear logic. The top generates 2**IDX_W instances plus the read muxes and the clear FSM.

Test Plan:
- Reset, then read indices 0 and 1023 -> both 10'h000; bht_busy_o=0.
- Speculative shifts of 1,1,0 at index 5, then read port 0 index 5 -> 10'b0000000110. With the macro, the third-cycle read already shows 10'b110.
- Commit 1 at index 5 (arch=10'b1); spec shifts 1,1 at index 5; recover -> next-cycle read of index 5 is 10'b0000000001, and dirty bits are clear.
- Same cycle: commit 1 to index 9 plus recover, with spec[9] dirty -> spec[9] becomes 10'b1 (post-commit arch value).
- Fill several entries, pulse bht_clear_req_i -> bht_busy_o high for exactly 32 cycles. Speculative shifts and commits inside that window are dropped. All entries read 0 afterwards.
- Assert reset_n low at sweep cycle 10 -> busy drops immediately; after release the table is all zero and the FSM is IDLE.
